game_of_life_scheduler: RTL and testbench

Sequencer for the serial GameOfLifeInterface. It takes a parallel board and a generation count from a host in a single handshake. It then shifts the board into the interface, holds `run` for the requested number of generations, and shifts the result back out into a parallel register. It flags a stable (unchanged) or extinct (all-dead) result, so the host never drives the bit-serial protocol itself.

---
 rtl/game_of_life_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_game_of_life_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_of_life_scheduler.sv
// Host-side sequencer for the bit-serial Game of Life interface.
// Accepts a parallel board plus generation count in one handshake, shifts the
// board in, runs the engine, shifts the result back out and reports whether it
// came back unchanged (stable) or empty (extinct).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; interface held in read mode, run low
// LOAD   | N cycles shifting the board into the interface, cell 0 first
// RUN    | run high for gen_count+1 cycles (1 engine load + 1 per generation)
// READ   | N+1 cycles in read mode; captures on the last N of them
// DONE   | one-cycle done pulse; results already registered
module game_of_life_scheduler #(
    parameter int ROW   = 6,
    parameter int COL   = 6,
    parameter int GEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [GEN_W-1:0]     gen_count,
    input  logic [ROW*COL-1:0]   board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROW*COL-1:0]   board_out,
    output logic                 stable,
    output logic                 extinct,
    output logic                 gol_run,
    output logic                 gol_write_read_not,
    output logic                 gol_serial_in,
    input  logic                 gol_serial_out
);

    localparam int N  = ROW * COL;
    localparam int BW = $clog2(N + 1);
    localparam int GW = GEN_W + 1;

    // Bit counter reload values: LOAD counts N-1..0, READ counts N..0.
    localparam logic [BW-1:0] BIT_LOAD_INIT = BW'(N - 1);
    localparam logic [BW-1:0] BIT_READ_INIT = BW'(N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_READ = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;

    logic [N-1:0]    shift_q, shift_d;
    logic [N-1:0]    ref_q, ref_d;
    logic [N-1:0]    capture_q, capture_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gen_cnt_q, gen_cnt_d;

    logic            busy_d;
    logic            done_d;
    logic [N-1:0]    board_out_d;
    logic            stable_d;
    logic            extinct_d;
    logic            run_d;
    logic            wrn_d;
    logic            serial_in_d;

    // Capture register with the incoming bit shifted into the MSB; the last
    // capture feeds board_out directly so results are valid on the done cycle.
    logic [N-1:0]    cap_shift;
    assign cap_shift = {gol_serial_out, capture_q[N-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-value logic for every registered output and counter.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        ref_d       = ref_q;
        capture_d   = capture_q;
        bit_cnt_d   = bit_cnt_q;
        gen_cnt_d   = gen_cnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        board_out_d = board_out;
        stable_d    = stable;
        extinct_d   = extinct;
        run_d       = gol_run;
        wrn_d       = gol_write_read_not;
        serial_in_d = gol_serial_in;

        case (state_q)
            S_IDLE: begin
                run_d = 1'b0;
                wrn_d = 1'b0;
                if (start) begin
                    state_d     = S_LOAD;
                    shift_d     = board_in >> 1;
                    ref_d       = board_in;
                    gen_cnt_d   = {1'b0, gen_count};
                    bit_cnt_d   = BIT_LOAD_INIT;
                    serial_in_d = board_in[0];
                    wrn_d       = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            S_LOAD: begin
                if (bit_cnt_q == '0) begin
                    state_d     = S_RUN;
                    run_d       = 1'b1;
                    wrn_d       = 1'b0;
                    serial_in_d = 1'b0;
                end else begin
                    serial_in_d = shift_q[0];
                    shift_d     = shift_q >> 1;
                    bit_cnt_d   = bit_cnt_q - 1'b1;
                end
            end

            S_RUN: begin
                if (gen_cnt_q == '0) begin
                    state_d   = S_READ;
                    run_d     = 1'b0;
                    bit_cnt_d = BIT_READ_INIT;
                end else begin
                    gen_cnt_d = gen_cnt_q - 1'b1;
                end
            end

            S_READ: begin
                // First READ cycle only launches the interface's read pipeline.
                if (bit_cnt_q != BIT_READ_INIT) begin
                    capture_d = cap_shift;
                end
                if (bit_cnt_q == '0) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    board_out_d = cap_shift;
                    stable_d    = (cap_shift == ref_q);
                    extinct_d   = (cap_shift == '0);
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q            <= '0;
            ref_q              <= '0;
            capture_q          <= '0;
            bit_cnt_q          <= '0;
            gen_cnt_q          <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            board_out          <= '0;
            stable             <= 1'b0;
            extinct            <= 1'b0;
            gol_run            <= 1'b0;
            gol_write_read_not <= 1'b0;
            gol_serial_in      <= 1'b0;
        end else begin
            shift_q            <= shift_d;
            ref_q              <= ref_d;
            capture_q          <= capture_d;
            bit_cnt_q          <= bit_cnt_d;
            gen_cnt_q          <= gen_cnt_d;
            busy               <= busy_d;
            done               <= done_d;
            board_out          <= board_out_d;
            stable             <= stable_d;
            extinct            <= extinct_d;
            gol_run            <= run_d;
            gol_write_read_not <= wrn_d;
            gol_serial_in      <= serial_in_d;
        end
    end

endmodule

// File: tb/tb_game_of_life_scheduler.sv
// Bench for game_of_life_scheduler: behavioural serial interface model,
// scoreboard of expected results and a monitor that checks on every done.
module tb_game_of_life_scheduler;

    localparam int ROW   = 6;
    localparam int COL   = 6;
    localparam int N     = ROW * COL;
    localparam int GEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [GEN_W-1:0] gen_count = '0;
    logic [N-1:0]     board_in = '0;
    logic             busy, done, stable, extinct;
    logic [N-1:0]     board_out;
    logic             gol_run, gol_write_read_not, gol_serial_in;
    logic             gol_serial_out = 1'b0;

    game_of_life_scheduler #(.ROW(ROW), .COL(COL), .GEN_W(GEN_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .gen_count          (gen_count),
        .board_in           (board_in),
        .busy               (busy),
        .done               (done),
        .board_out          (board_out),
        .stable             (stable),
        .extinct            (extinct),
        .gol_run            (gol_run),
        .gol_write_read_not (gol_write_read_not),
        .gol_serial_in      (gol_serial_in),
        .gol_serial_out     (gol_serial_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One generation on a ROWxCOL grid; cells beyond the edge are dead.
    function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
        logic [N-1:0] o;
        o = '0;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROW &&
                            c + dc >= 0 && c + dc < COL)
                            cnt += int'(b[(r + dr) * COL + c + dc]);
                if (b[r * COL + c]) o[r * COL + c] = (cnt == 2 || cnt == 3);
                else                o[r * COL + c] = (cnt == 3);
            end
        end
        return o;
    endfunction

    // Serial interface model: right-shift load, engine load on first run
    // cycle, one generation per further run cycle, registered read-out.
    logic [N-1:0] if_shift  = '0;
    logic [N-1:0] if_engine = '0;
    logic         if_run_q  = 1'b0;
    int           if_rd_idx = 0;
    always @(posedge clk) begin
        if (gol_run) begin
            if (!if_run_q) if_engine <= if_shift;
            else           if_engine <= life_step(if_engine);
            if_rd_idx <= 0;
        end else if (gol_write_read_not) begin
            if_shift  <= {gol_serial_in, if_shift[N-1:1]};
            if_rd_idx <= 0;
        end else begin
            gol_serial_out <= if_engine[if_rd_idx];
            if_rd_idx      <= (if_rd_idx + 1) % N;
        end
        if_run_q <= gol_run;
    end

    typedef struct {
        logic [N-1:0] board;
        logic         stable;
        logic         extinct;
        int           lat;
        int           t0;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: compare results on done, enforce busy and board_out hold.
    logic [N-1:0] held_board = '0;
    always @(negedge clk) begin
        if (rst) begin
            held_board = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done with no pending request (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("board_out", 64'(board_out), 64'(e.board));
                chk("stable",    64'(stable),    64'(e.stable));
                chk("extinct",   64'(extinct),   64'(e.extinct));
                chk("latency",   64'(cyc - e.t0), 64'(e.lat));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            held_board = board_out;
        end else begin
            if (board_out !== held_board)
                chk("board_out_hold", 64'(board_out), 64'(held_board));
            if (exp_q.size() > 0)
                chk("busy_during_op", 64'(busy), 64'd1);
        end
    end

    // Issue one request; returns at the negedge after the accepting edge.
    task automatic issue(input logic [N-1:0] b, input int g);
        exp_t e;
        int   guard;
        logic [N-1:0] res;
        guard = 0;
        while (busy && guard < 2000) begin @(negedge clk); guard++; end
        board_in  = b;
        gen_count = GEN_W'(g);
        start     = 1'b1;
        do begin @(negedge clk); guard++; end while (!busy && guard < 2000);
        start = 1'b0;
        if (guard >= 2000) begin
            checks++;
            $display("FAIL accept_timeout: busy never rose (cycle %0d)", cyc);
        end
        res = b;
        for (int i = 0; i < g; i++) res = life_step(res);
        e.board   = res;
        e.stable  = (res == b);
        e.extinct = (res == '0);
        e.lat     = 2 * N + 2 + g;
        e.t0      = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin @(negedge clk); guard++; end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL done_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [N-1:0] blinker, block, single, rb;
    logic [63:0]  r64;

    initial begin
        blinker = '0; blinker[13] = 1'b1; blinker[14] = 1'b1; blinker[15] = 1'b1;
        block   = '0; block[14] = 1'b1; block[15] = 1'b1; block[20] = 1'b1; block[21] = 1'b1;
        single  = '0; single[0] = 1'b1;

        #1;
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_board_out", 64'(board_out), 64'd0);
        chk("rst_stable",    64'(stable),    64'd0);
        chk("rst_extinct",   64'(extinct),   64'd0);
        chk("rst_run",       64'(gol_run),   64'd0);
        chk("rst_wrn",       64'(gol_write_read_not), 64'd0);
        chk("rst_sin",       64'(gol_serial_in), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(blinker, 1);
        issue(blinker, 2);
        issue(block, 0);
        issue(block, 255);
        issue(single, 1);
        drain();

        // Spurious start pulses during LOAD, RUN and READ.
        issue(blinker, 10);
        repeat (4) @(negedge clk);
        board_in = '1; start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (N) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("no_second_done", 64'(done), 64'd0);

        // Reset in the middle of RUN.
        issue(blinker, 1);
        repeat (N + 1) @(negedge clk);
        chk("mid_run_active", 64'(gol_run), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy),    64'd0);
        chk("abort_run",  64'(gol_run), 64'd0);
        chk("abort_wrn",  64'(gol_write_read_not), 64'd0);
        chk("abort_done", 64'(done),    64'd0);
        chk("abort_board_out", 64'(board_out), 64'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(blinker, 1);
        drain();

        // Randomized boards and generation counts, issued back-to-back.
        for (int k = 0; k < 12; k++) begin
            r64 = {$urandom(), $urandom()};
            rb  = r64[N-1:0];
            if (k % 4 == 3) rb = rb & {$urandom(), $urandom()};
            issue(rb, int'($urandom_range(0, 20)));
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
